// File: rtl/carbon_fabric_sim_mmio.sv
// Simulation/bring-up MMIO target: SIGNATURE register, sticky POWEROFF flag and an
// optional byte console FIFO enabled by defining CARBON_SIM_MMIO_CONSOLE_EN.
module carbon_fabric_sim_mmio #(
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0000,
  parameter int unsigned WIN_BYTES   = 256,
  parameter int unsigned RSP_LATENCY = 1,
  parameter int unsigned RSP_OK      = 0,
  parameter int unsigned RSP_ERR     = 2,
  parameter int unsigned CON_DEPTH   = 8,
  parameter int unsigned FAB_ADDR_W  = 32,
  parameter int unsigned FAB_DATA_W  = 32,
  parameter int unsigned FAB_ID_W    = 4,
  parameter int unsigned FAB_OP_W    = 2,
  parameter int unsigned FAB_SIZE_W  = 2,
  parameter int unsigned FAB_ATTR_W  = 4,
  parameter int unsigned FAB_CODE_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FAB_ID_W-1:0]     req_id,
  input  logic [FAB_ADDR_W-1:0]   req_addr,
  input  logic [FAB_OP_W-1:0]     req_op,
  input  logic [FAB_DATA_W-1:0]   req_wdata,
  input  logic [FAB_DATA_W/8-1:0] req_wstrb,
  input  logic [FAB_SIZE_W-1:0]   req_size,
  input  logic [FAB_ATTR_W-1:0]   req_attr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FAB_DATA_W-1:0]   rsp_rdata,
  output logic [FAB_CODE_W-1:0]   rsp_code,
  output logic [FAB_ID_W-1:0]     rsp_id,
  output logic [31:0]             signature_o,
  output logic                    sig_written_o,
  output logic                    poweroff_o,
  output logic                    con_valid_o,
  output logic [7:0]              con_data_o,
  input  logic                    con_ready_i
);
  localparam logic [FAB_ADDR_W-1:0] BASE                      = FAB_ADDR_W'(MMIO_BASE);
  localparam logic [FAB_ADDR_W-1:0] CARBON_MMIO_SIGNATURE_OFF = FAB_ADDR_W'(32'h0);
  localparam logic [FAB_ADDR_W-1:0] CARBON_MMIO_POWEROFF_OFF  = FAB_ADDR_W'(32'h4);
  localparam logic [FAB_ADDR_W-1:0] CARBON_MMIO_CONSOLE_OFF   = FAB_ADDR_W'(32'h8);
  localparam logic [FAB_OP_W-1:0]   CARBON_FABRIC_XACT_READ   = FAB_OP_W'(1);
  localparam logic [FAB_OP_W-1:0]   CARBON_FABRIC_XACT_WRITE  = FAB_OP_W'(2);
  localparam logic [FAB_CODE_W-1:0] CODE_OK  = FAB_CODE_W'(RSP_OK);
  localparam logic [FAB_CODE_W-1:0] CODE_ERR = FAB_CODE_W'(RSP_ERR);

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;
  state_t state;
  logic [3:0] cnt;

  logic [FAB_ADDR_W-1:0] off;
  logic in_win, is_rd, is_wr, hit_sig, hit_pow, hit_con, con_blk, dec_ok, accept;
  logic [31:0] rd_val, sig_merged, con_free;
  logic unused_ok;

  assign off       = req_addr - BASE;
  assign in_win    = (off < FAB_ADDR_W'(WIN_BYTES)) && (off[1:0] == 2'b00);
  assign is_rd     = req_op == CARBON_FABRIC_XACT_READ;
  assign is_wr     = req_op == CARBON_FABRIC_XACT_WRITE;
  assign hit_sig   = in_win && (off == CARBON_MMIO_SIGNATURE_OFF);
  assign hit_pow   = in_win && (off == CARBON_MMIO_POWEROFF_OFF);
  assign dec_ok    = (is_rd || is_wr) && (hit_sig || hit_pow || hit_con) && !con_blk;
  assign req_ready = state == IDLE;
  assign accept    = req_valid && req_ready;
  assign unused_ok = ^{req_size, req_attr, req_wdata, req_wstrb, con_ready_i};

  always_comb begin
    sig_merged = signature_o;
    for (int i = 0; i < 4; i++)
      if (req_wstrb[i]) sig_merged[8*i +: 8] = req_wdata[8*i +: 8];
  end

  always_comb begin
    rd_val = '0;
    if (hit_sig)      rd_val = signature_o;
    else if (hit_pow) rd_val = {31'b0, poweroff_o};
    else if (hit_con) rd_val = con_free;
  end

`ifdef CARBON_SIM_MMIO_CONSOLE_EN
  localparam int unsigned CW = $clog2(CON_DEPTH);
  logic [7:0]    con_mem [CON_DEPTH];
  logic [CW-1:0] con_wp, con_rp;
  logic [CW:0]   con_cnt;
  logic          con_pop, con_push, con_full;

  assign hit_con     = in_win && (off == CARBON_MMIO_CONSOLE_OFF);
  assign con_valid_o = con_cnt != '0;
  assign con_data_o  = con_mem[con_rp];
  assign con_pop     = con_valid_o && con_ready_i;
  assign con_full    = con_cnt == (CW+1)'(CON_DEPTH);
  // A full FIFO still takes the byte if a pop frees a slot on the same edge.
  assign con_blk     = hit_con && is_wr && req_wstrb[0] && con_full && !con_pop;
  assign con_push    = accept && hit_con && is_wr && req_wstrb[0] && !con_blk;
  assign con_free    = 32'(CON_DEPTH) - 32'(con_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      con_wp  <= '0;
      con_rp  <= '0;
      con_cnt <= '0;
    end else begin
      if (con_push) begin
        con_mem[con_wp] <= req_wdata[7:0];
        con_wp          <= con_wp + 1'b1;
      end
      if (con_pop) con_rp <= con_rp + 1'b1;
      con_cnt <= con_cnt + {{CW{1'b0}}, con_push} - {{CW{1'b0}}, con_pop};
    end
  end
`else
  assign hit_con     = 1'b0;
  assign con_blk     = 1'b0;
  assign con_free    = '0;
  assign con_valid_o = 1'b0;
  assign con_data_o  = '0;
`endif

  // Side effects commit on the accept edge; the response is only delayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_code      <= '0;
      rsp_id        <= '0;
      signature_o   <= '0;
      sig_written_o <= 1'b0;
      poweroff_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rsp_id    <= req_id;
          rsp_code  <= dec_ok ? CODE_OK : CODE_ERR;
          rsp_rdata <= (dec_ok && is_rd) ? FAB_DATA_W'(rd_val) : '0;
          cnt       <= 4'(RSP_LATENCY - 2);
          if (RSP_LATENCY == 1) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
          if (dec_ok && is_wr && hit_sig && |req_wstrb[3:0]) begin
            signature_o   <= sig_merged;
            sig_written_o <= 1'b1;
          end
          if (dec_ok && is_wr && hit_pow && req_wstrb[0] && req_wdata[0]) poweroff_o <= 1'b1;
        end
        WAIT: if (cnt == '0) begin
          state     <= RSP;
          rsp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RSP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_carbon_fabric_sim_mmio.sv
// Bench: two DUTs (latency 1 and 4) see identical traffic; table vectors, directed
// corner sequences and random traffic against a queue/array reference model.
module tb_carbon_fabric_sim_mmio;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WIN   = 256;
  localparam int          DEPTH = 2;
  localparam logic [1:0]  OP_RD = 2'd1, OP_WR = 2'd2, OK = 2'd0, ERR = 2'd2;

  logic clk, rst, req_valid, rsp_ready, con_ready_i;
  logic [3:0] req_id, req_wstrb, req_attr;
  logic [31:0] req_addr, req_wdata;
  logic [1:0] req_op, req_size;
  logic req_ready [2], rsp_valid [2], sig_written_o [2], poweroff_o [2], con_valid_o [2];
  logic [31:0] rsp_rdata [2], signature_o [2];
  logic [1:0] rsp_code [2];
  logic [3:0] rsp_id [2];
  logic [7:0] con_data_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    carbon_fabric_sim_mmio #(
      .MMIO_BASE(BASE), .WIN_BYTES(WIN), .RSP_LATENCY(g == 0 ? 1 : 4),
      .RSP_OK(0), .RSP_ERR(2), .CON_DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_id(req_id), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb), .req_size(req_size), .req_attr(req_attr),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]),
      .rsp_code(rsp_code[g]), .rsp_id(rsp_id[g]), .signature_o(signature_o[g]),
      .sig_written_o(sig_written_o[g]), .poweroff_o(poweroff_o[g]),
      .con_valid_o(con_valid_o[g]), .con_data_o(con_data_o[g]), .con_ready_i(con_ready_i)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: architectural state only, no notion of FSM or timing.
  logic [31:0] m_sig;
  logic        m_sw, m_pow;
  logic [7:0]  m_con [$];

  task automatic model_reset();
    m_sig = '0; m_sw = 1'b0; m_pow = 1'b0; m_con.delete();
  endtask

  task automatic model(input logic [31:0] addr, input logic [1:0] op, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [1:0] code, output logic [31:0] rd);
    logic [31:0] off;
    off = addr - BASE;
    code = ERR;
    rd = '0;
    if ((op == OP_RD || op == OP_WR) && off < WIN && off % 4 == 0) begin
      if (off == 0) begin
        code = OK;
        if (op == OP_RD) rd = m_sig;
        else begin
          for (int b = 0; b < 4; b++) if (ws[b]) m_sig[8*b +: 8] = wd[8*b +: 8];
          if (ws != 0) m_sw = 1'b1;
        end
      end else if (off == 4) begin
        code = OK;
        if (op == OP_RD) rd = {31'b0, m_pow};
        else if (ws[0] && wd[0]) m_pow = 1'b1;
      end
`ifdef CARBON_SIM_MMIO_CONSOLE_EN
      else if (off == 8) begin
        if (op == OP_RD) begin
          code = OK;
          rd = 32'(DEPTH - m_con.size());
        end else if (!ws[0]) code = OK;
        else if (m_con.size() < DEPTH) begin
          code = OK;
          m_con.push_back(wd[7:0]);
        end
      end
`endif
    end
  endtask

  // One transaction with rsp_ready high; latency, id, code and data checked per DUT.
  task automatic do_xact(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] op,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] ecode,
                         input logic [31:0] erd, input string nm);
    bit got [2];
    int lat [2];
    logic [1:0] gc [2];
    logic [31:0] gd [2];
    logic [3:0] gi [2];
    bit busy_ok;
    for (int i = 0; i < 2; i++) begin got[i] = 0; lat[i] = 0; gc[i] = '0; gd[i] = '0; gi[i] = '0; end
    chk($sformatf("%s.idle_rdy", nm), {req_ready[1], req_ready[0]}, 2'b11);
    req_valid = 1'b1; req_id = id; req_addr = addr; req_op = op; req_wdata = wd; req_wstrb = ws;
    req_size = 2'($urandom); req_attr = 4'($urandom); rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_id = 4'($urandom);
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      for (int i = 0; i < 2; i++) if (!got[i] && req_ready[i]) busy_ok = 1'b0;
      for (int i = 0; i < 2; i++)
        if (!got[i] && rsp_valid[i]) begin
          got[i] = 1; lat[i] = k; gc[i] = rsp_code[i]; gd[i] = rsp_rdata[i]; gi[i] = rsp_id[i];
        end
      if (got[0] && got[1]) break;
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    chk($sformatf("%s.busy_rdy", nm), busy_ok, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.d%0d.got", nm, i), got[i], 1'b1);
      chk($sformatf("%s.d%0d.lat", nm, i), lat[i], (i == 0) ? 1 : 4);
      chk($sformatf("%s.d%0d.code", nm, i), gc[i], ecode);
      chk($sformatf("%s.d%0d.rdata", nm, i), gd[i], erd);
      chk($sformatf("%s.d%0d.id", nm, i), gi[i], id);
    end
  endtask

  task automatic chk_state(input string nm, input logic [31:0] sig, input logic sw, input logic pow);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.d%0d.sig", nm, i), signature_o[i], sig);
      chk($sformatf("%s.d%0d.sigw", nm, i), sig_written_o[i], sw);
      chk($sformatf("%s.d%0d.pow", nm, i), poweroff_o[i], pow);
    end
  endtask

  typedef struct {
    logic [31:0] addr; logic [1:0] op; logic [31:0] wd; logic [3:0] ws;
    logic [1:0] code; logic [31:0] rd; logic [31:0] sig; logic sw; logic pow;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(logic [31:0] a, logic [1:0] op, logic [31:0] wd, logic [3:0] ws,
                              logic [1:0] c, logic [31:0] rd, logic [31:0] sig, logic sw, logic pow);
    vec_t v;
    v.addr = a; v.op = op; v.wd = wd; v.ws = ws; v.code = c; v.rd = rd; v.sig = sig; v.sw = sw; v.pow = pow;
    tbl.push_back(v);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] ec, op;
    logic [31:0] er, addr;
    rst = 1'b1; req_valid = 1'b0; req_id = '0; req_addr = '0; req_op = '0; req_wdata = '0;
    req_wstrb = '0; req_size = '0; req_attr = '0; rsp_ready = 1'b0; con_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst.d%0d.flags", i),
          {req_ready[i], rsp_valid[i], sig_written_o[i], poweroff_o[i], con_valid_o[i]}, 5'b10000);
      chk($sformatf("rst.d%0d.rsp", i), {rsp_rdata[i], rsp_code[i], rsp_id[i]}, '0);
      chk($sformatf("rst.d%0d.sig", i), signature_o[i], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    add(BASE,         OP_WR, 32'hDEAD_BEEF, 4'h0, OK,  0, 32'h0, 0, 0);
`ifdef CARBON_SIM_MMIO_CONSOLE_EN
    add(BASE + 8,     OP_RD, 32'h0,         4'h0, OK,  2, 32'h0, 0, 0);
`else
    add(BASE + 8,     OP_RD, 32'h0,         4'h0, ERR, 0, 32'h0, 0, 0);
`endif
    add(BASE,         OP_WR, 32'hC0DE_0001, 4'hF, OK,  0, 32'hC0DE_0001, 1, 0);
    add(BASE,         OP_WR, 32'h00AA_0000, 4'h4, OK,  0, 32'hC0AA_0001, 1, 0);
    add(BASE,         OP_RD, 32'h0,         4'h0, OK,  32'hC0AA_0001, 32'hC0AA_0001, 1, 0);
    add(BASE + WIN,   OP_RD, 32'h0,         4'h0, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE + 2,     OP_RD, 32'h0,         4'h0, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE + 2,     OP_WR, 32'hFFFF_FFFF, 4'hF, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE,         2'd0,  32'hFFFF_FFFF, 4'hF, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE,         2'd3,  32'hFFFF_FFFF, 4'hF, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE - 4,     OP_RD, 32'h0,         4'h0, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE + 'hFC,  OP_RD, 32'h0,         4'h0, ERR, 0, 32'hC0AA_0001, 1, 0);
    add(BASE + 4,     OP_WR, 32'h0000_0001, 4'hE, OK,  0, 32'hC0AA_0001, 1, 0);
    add(BASE + 4,     OP_RD, 32'h0,         4'h0, OK,  0, 32'hC0AA_0001, 1, 0);
    add(BASE + 4,     OP_WR, 32'h0000_0001, 4'h1, OK,  0, 32'hC0AA_0001, 1, 1);
    add(BASE + 4,     OP_WR, 32'h0000_0000, 4'h1, OK,  0, 32'hC0AA_0001, 1, 1);
    add(BASE + 4,     OP_RD, 32'h0,         4'h0, OK,  1, 32'hC0AA_0001, 1, 1);

    foreach (tbl[n]) begin
      model(tbl[n].addr, tbl[n].op, tbl[n].wd, tbl[n].ws, ec, er);
      do_xact(4'(n), tbl[n].addr, tbl[n].op, tbl[n].wd, tbl[n].ws, tbl[n].code, tbl[n].rd,
              $sformatf("tbl%0d", n));
      chk_state($sformatf("tbl%0d", n), tbl[n].sig, tbl[n].sw, tbl[n].pow);
    end

    // Latency 4 with a stalled consumer: response must hold until rsp_ready.
    req_valid = 1'b1; req_id = 4'd5; req_addr = BASE; req_op = OP_RD; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_id = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("hold.k%0d.valid", k), {rsp_valid[1], rsp_valid[0]}, {k >= 4, 1'b1});
      chk($sformatf("hold.k%0d.rdy", k), {req_ready[1], req_ready[0]}, 2'b00);
      if (k >= 4) chk($sformatf("hold.k%0d.rsp", k), {rsp_id[1], rsp_code[1], rsp_rdata[1]},
                      {4'd5, OK, 32'hC0AA_0001});
      if (k == 7) rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("hold.after", {rsp_valid[1], rsp_valid[0], req_ready[1], req_ready[0]}, 4'b0011);

    // Reset while a response is pending.
    req_valid = 1'b1; req_id = 4'd9; req_addr = BASE; req_op = OP_RD; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("midrst.pending", rsp_valid[0], 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst.flags", {rsp_valid[1], rsp_valid[0], req_ready[1], req_ready[0]}, 4'b0011);
    chk_state("midrst", 32'h0, 1'b0, 1'b0);

`ifdef CARBON_SIM_MMIO_CONSOLE_EN
    con_ready_i = 1'b0;
    model(BASE + 8, OP_WR, 32'h41, 4'h1, ec, er); do_xact(4'd1, BASE + 8, OP_WR, 32'h41, 4'h1, OK,  0, "conA");
    model(BASE + 8, OP_WR, 32'h42, 4'h1, ec, er); do_xact(4'd2, BASE + 8, OP_WR, 32'h42, 4'h1, OK,  0, "conB");
    model(BASE + 8, OP_WR, 32'h43, 4'h1, ec, er); do_xact(4'd3, BASE + 8, OP_WR, 32'h43, 4'h1, ERR, 0, "conC");
    do_xact(4'd4, BASE + 8, OP_RD, 32'h0, 4'h0, OK, 0, "con.free0");
    chk("con.head", {con_valid_o[1], con_data_o[1], con_valid_o[0], con_data_o[0]}, {1'b1, 8'h41, 1'b1, 8'h41});
    con_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("con.second", {con_valid_o[1], con_data_o[1], con_valid_o[0], con_data_o[0]}, {1'b1, 8'h42, 1'b1, 8'h42});
    @(posedge clk); @(negedge clk);
    chk("con.empty", {con_valid_o[1], con_valid_o[0]}, 2'b00);
    con_ready_i = 1'b0;
    m_con.delete();
    do_xact(4'd5, BASE + 8, OP_WR, 32'h44, 4'h1, OK, 0, "conD");
    do_xact(4'd6, BASE + 8, OP_WR, 32'h45, 4'h1, OK, 0, "conE");
    con_ready_i = 1'b1;
    do_xact(4'd7, BASE + 8, OP_WR, 32'h46, 4'h1, OK, 0, "con.fullpop");
    chk("con.drained", {con_valid_o[1], con_valid_o[0]}, 2'b00);
    con_ready_i = 1'b0;
`endif

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(7))
        0: addr = BASE;
        1: addr = BASE + 4;
        2: addr = BASE + 8;
        3: addr = BASE + 2;
        4: addr = BASE + WIN;
        5: addr = BASE + WIN - 4;
        6: addr = BASE + $urandom_range(255);
        default: addr = $urandom;
      endcase
      op = ($urandom_range(3) == 0) ? 2'($urandom) : ($urandom_range(1) == 1 ? OP_RD : OP_WR);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      er = req_wdata;
      model(addr, op, er, req_wstrb, ec, er);
      do_xact(4'($urandom), addr, op, req_wdata, req_wstrb, ec, er, $sformatf("rnd%0d", n));
      chk_state($sformatf("rnd%0d", n), m_sig, m_sw, m_pow);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
